// File: rtl/chip8_call_controller.sv
// CALL/RET sequencer for Chip8_Stack: timed push/pop strobes, depth tracking, overflow/underflow detection.
// Define CHIP8_STACK_TRAP_EN to make faults sticky (FAULT state held until reset).
module chip8_call_controller #(
  parameter int STACK_DEPTH = 16,
  parameter int WE_HOLD     = 2
) (
  input  logic        cpu_clk,
  input  logic        reset,
  input  logic        call_req,
  input  logic        ret_req,
  input  logic [11:0] call_target,
  input  logic [11:0] pc_in,
  output logic [1:0]  stk_we,
  output logic [15:0] stk_writedata,
  input  logic [15:0] stk_outdata,
  output logic        pc_load,
  output logic [11:0] pc_next,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [4:0]  depth
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_PUSH     = 3'd1;
  localparam logic [2:0] S_POP      = 3'd2;
  localparam logic [2:0] S_SETTLE   = 3'd3;
  localparam logic [2:0] S_COMPLETE = 3'd4;
  localparam logic [2:0] S_FAULT    = 3'd5;

  localparam logic [7:0] HOLD_LAST = 8'(WE_HOLD - 1);
  localparam logic [4:0] DEPTH_MAX = 5'(STACK_DEPTH);

  logic [2:0]  state;
  logic [7:0]  hold_cnt;
  logic        op_ret;
  logic [11:0] target_q;
  logic        fault_seen;
  logic        unused_outdata_hi;

  assign unused_outdata_hi = ^stk_outdata[15:12];

  always_ff @(posedge cpu_clk) begin
    if (reset) begin
      state         <= S_IDLE;
      hold_cnt      <= '0;
      op_ret        <= 1'b0;
      target_q      <= '0;
      stk_writedata <= '0;
      depth         <= '0;
      fault_seen    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          hold_cnt   <= '0;
          fault_seen <= 1'b0;
          if (call_req) begin
            if (depth == DEPTH_MAX) begin
              state <= S_FAULT;
            end else begin
              state         <= S_PUSH;
              op_ret        <= 1'b0;
              target_q      <= call_target;
              stk_writedata <= {4'h0, pc_in + 12'd2};
            end
          end else if (ret_req) begin
            if (depth == '0) begin
              state <= S_FAULT;
            end else begin
              state  <= S_POP;
              op_ret <= 1'b1;
            end
          end
        end
        S_PUSH, S_POP: begin
          if (hold_cnt == HOLD_LAST) state <= S_SETTLE;
          else hold_cnt <= hold_cnt + 8'd1;
        end
        S_SETTLE: begin
          // depth moves on entry to COMPLETE so it is already current alongside done
          state <= S_COMPLETE;
          depth <= op_ret ? depth - 5'd1 : depth + 5'd1;
        end
        S_COMPLETE: state <= S_IDLE;
        S_FAULT: begin
          fault_seen <= 1'b1;
`ifdef CHIP8_STACK_TRAP_EN
          state <= S_FAULT;
`else
          state <= S_IDLE;
`endif
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    stk_we = 2'b00;
    if (state == S_PUSH) stk_we = 2'b01;
    else if (state == S_POP) stk_we = 2'b10;
  end

  // RET return address is taken straight from the stack while in COMPLETE
  always_comb begin
    pc_next = '0;
    if (state == S_COMPLETE) pc_next = op_ret ? stk_outdata[11:0] : target_q;
  end

  assign pc_load = (state == S_COMPLETE);
  assign busy    = (state != S_IDLE);
  assign done    = (state == S_COMPLETE) || ((state == S_FAULT) && !fault_seen);
  assign err     = (state == S_FAULT);

endmodule

// File: tb/tb_chip8_call_controller.sv
// Directed bench for chip8_call_controller with a behavioural Chip8_Stack model.
// Fault expectations follow CHIP8_STACK_TRAP_EN when it is defined for the build.
module tb_chip8_call_controller;

  logic        cpu_clk = 1'b0;
  logic        reset;
  logic        call_req;
  logic        ret_req;
  logic [11:0] call_target;
  logic [11:0] pc_in;
  logic [1:0]  stk_we;
  logic [15:0] stk_writedata;
  logic [15:0] stk_outdata;
  logic        pc_load;
  logic [11:0] pc_next;
  logic        busy;
  logic        done;
  logic        err;
  logic [4:0]  depth;

  int checks = 0;
  int errors = 0;

  chip8_call_controller #(.STACK_DEPTH(16), .WE_HOLD(2)) dut (
    .cpu_clk(cpu_clk), .reset(reset), .call_req(call_req), .ret_req(ret_req),
    .call_target(call_target), .pc_in(pc_in), .stk_we(stk_we),
    .stk_writedata(stk_writedata), .stk_outdata(stk_outdata), .pc_load(pc_load),
    .pc_next(pc_next), .busy(busy), .done(done), .err(err), .depth(depth)
  );

  always #5 cpu_clk = ~cpu_clk;

  // Stack model: one push/pop per WE assertion, acting on the rising WE edge
  logic [15:0] mem [0:31];
  logic [4:0]  sp;
  logic [1:0]  we_q;
  always @(posedge cpu_clk) begin
    if (reset) begin
      sp <= '0; we_q <= 2'b00; stk_outdata <= '0;
    end else begin
      we_q <= stk_we;
      if (stk_we == 2'b01 && we_q == 2'b00) begin
        mem[sp] <= stk_writedata; sp <= sp + 5'd1;
      end else if (stk_we == 2'b10 && we_q == 2'b00) begin
        stk_outdata <= mem[sp - 5'd1]; sp <= sp - 5'd1;
      end
    end
  end

  task automatic tick();
    @(posedge cpu_clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // mode: 0 CALL, 1 RET, 2 CALL and RET together (RET held while busy)
  typedef struct {
    logic [1:0]  mode;
    logic [11:0] pc;
    logic [11:0] tgt;
    logic [11:0] exp_pc;
    logic [4:0]  exp_depth;
  } vec_t;

  task automatic run_op(input string name, input logic [1:0] mode, input logic [11:0] pc,
                        input logic [11:0] tgt, input logic [11:0] exp_pc, input logic [4:0] exp_depth);
    logic       is_call;
    logic       seen;
    logic       we_bad;
    logic [1:0] we_exp;
    int         lat;
    is_call = (mode != 2'd1);
    call_req = is_call; ret_req = (mode != 2'd0); pc_in = pc; call_target = tgt;
    tick();
    call_req = 1'b0;
    if (mode != 2'd2) ret_req = 1'b0;
    seen = 1'b0; we_bad = 1'b0; lat = 0;
    for (int k = 1; k <= 10 && !seen; k++) begin
      we_exp = (k <= 2) ? (is_call ? 2'b01 : 2'b10) : 2'b00;
      if (stk_we == 2'b11 || (k <= 3 && stk_we != we_exp)) we_bad = 1'b1;
      if (done) begin
        seen = 1'b1; lat = k;
        ret_req = 1'b0;
        chk({name, "_pc_load"}, 32'(pc_load), 32'd1);
        chk({name, "_pc_next"}, 32'(pc_next), 32'(exp_pc));
        chk({name, "_err"}, 32'(err), 32'd0);
        chk({name, "_depth"}, 32'(depth), 32'(exp_depth));
        if (is_call) chk({name, "_wdata"}, 32'(stk_writedata), 32'({4'h0, pc + 12'd2}));
      end else begin
        tick();
      end
    end
    chk({name, "_latency"}, 32'(lat), 32'd4);
    chk({name, "_we_seq"}, 32'(we_bad), 32'd0);
    ret_req = 1'b0;
    tick();
    chk({name, "_idle"}, 32'(busy), 32'd0);
  endtask

  task automatic fault_check(input string name, input logic is_call, input logic [4:0] exp_depth);
    call_req = is_call; ret_req = !is_call;
    tick();
    call_req = 1'b0; ret_req = 1'b0;
    chk({name, "_we"}, 32'(stk_we), 32'd0);
    chk({name, "_err"}, 32'(err), 32'd1);
    chk({name, "_done"}, 32'(done), 32'd1);
    chk({name, "_pc_load"}, 32'(pc_load), 32'd0);
    chk({name, "_depth"}, 32'(depth), 32'(exp_depth));
`ifdef CHIP8_STACK_TRAP_EN
    call_req = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk({name, "_trap_err"}, 32'(err), 32'd1);
      chk({name, "_trap_busy"}, 32'(busy), 32'd1);
      chk({name, "_trap_done"}, 32'(done), 32'd0);
      chk({name, "_trap_we"}, 32'(stk_we), 32'd0);
    end
    call_req = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk({name, "_trap_clr"}, 32'({err, busy, depth}), 32'd0);
`else
    tick();
    chk({name, "_pulse_err"}, 32'(err), 32'd0);
    chk({name, "_pulse_done"}, 32'(done), 32'd0);
    chk({name, "_pulse_busy"}, 32'(busy), 32'd0);
    chk({name, "_pulse_depth"}, 32'(depth), 32'(exp_depth));
`endif
  endtask

  vec_t vecs [14];

  initial begin
    vecs[0]  = '{2'd0, 12'h200, 12'h300, 12'h300, 5'd1};
    vecs[1]  = '{2'd1, 12'h000, 12'h000, 12'h202, 5'd0};
    vecs[2]  = '{2'd0, 12'h200, 12'h500, 12'h500, 5'd1};
    vecs[3]  = '{2'd0, 12'h300, 12'h600, 12'h600, 5'd2};
    vecs[4]  = '{2'd0, 12'h400, 12'h700, 12'h700, 5'd3};
    vecs[5]  = '{2'd1, 12'h000, 12'h000, 12'h402, 5'd2};
    vecs[6]  = '{2'd1, 12'h000, 12'h000, 12'h302, 5'd1};
    vecs[7]  = '{2'd1, 12'h000, 12'h000, 12'h202, 5'd0};
    vecs[8]  = '{2'd0, 12'h123, 12'h456, 12'h456, 5'd1};
    vecs[9]  = '{2'd2, 12'h250, 12'h800, 12'h800, 5'd2};
    vecs[10] = '{2'd1, 12'h000, 12'h000, 12'h252, 5'd1};
    vecs[11] = '{2'd1, 12'h000, 12'h000, 12'h125, 5'd0};
    vecs[12] = '{2'd0, 12'hFFE, 12'h0AB, 12'h0AB, 5'd1};
    vecs[13] = '{2'd1, 12'h000, 12'h000, 12'h000, 5'd0};

    reset = 1'b1; call_req = 1'b0; ret_req = 1'b0; pc_in = '0; call_target = '0;
    tick(); tick();
    chk("reset_we", 32'(stk_we), 32'd0);
    chk("reset_wdata", 32'(stk_writedata), 32'd0);
    chk("reset_pc", 32'({pc_load, pc_next}), 32'd0);
    chk("reset_flags", 32'({busy, done, err}), 32'd0);
    chk("reset_depth", 32'(depth), 32'd0);
    reset = 1'b0;
    tick();

    for (int i = 0; i < 14; i++)
      run_op($sformatf("vec%0d", i), vecs[i].mode, vecs[i].pc, vecs[i].tgt,
             vecs[i].exp_pc, vecs[i].exp_depth);

    fault_check("underflow", 1'b0, 5'd0);
`ifndef CHIP8_STACK_TRAP_EN
    run_op("after_underflow", 2'd0, 12'h220, 12'h330, 12'h330, 5'd1);
    run_op("after_underflow_ret", 2'd1, 12'h000, 12'h000, 12'h222, 5'd0);
`endif

    for (int i = 0; i < 16; i++)
      run_op($sformatf("fill%0d", i), 2'd0, 12'(12'h100 + 12'(i * 16)), 12'(12'h800 + i),
             12'(12'h800 + i), 5'(i + 1));
    fault_check("overflow", 1'b1, 5'd16);
`ifndef CHIP8_STACK_TRAP_EN
    run_op("after_overflow_ret", 2'd1, 12'h000, 12'h000, 12'h1F2, 5'd15);
`endif

    // Reset during the second PUSH cycle, then a wrapping CALL
    reset = 1'b1; tick(); reset = 1'b0; tick();
    run_op("pre_abort", 2'd0, 12'h200, 12'h300, 12'h300, 5'd1);
    call_req = 1'b1; pc_in = 12'h500; call_target = 12'h600;
    tick();
    call_req = 1'b0;
    chk("abort_push1", 32'(stk_we), 32'd1);
    tick();
    chk("abort_push2", 32'(stk_we), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("abort_we", 32'(stk_we), 32'd0);
    chk("abort_depth", 32'(depth), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    run_op("wrap_call", 2'd0, 12'hFFE, 12'h3A0, 12'h3A0, 5'd1);
    chk("wrap_wdata", 32'(stk_writedata), 32'h0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
